// File: rtl/control_sequencer_if.sv
// Control-word write port, sync input and per-channel status/event outputs of
// control_sequencer, bundled so the sequencer and its driver share one definition.
interface control_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int SYNC_W = 2,
    parameter int MODE_W = 3
);
    localparam int CTRL_W = 6 * NUM_CH + SYNC_W + MODE_W;

    logic                  ctrl_wr;
    logic [CTRL_W-1:0]     ctrl_data;
    logic                  sync_tick;
    logic                  ctrl_ack;
    logic [NUM_CH-1:0]     ch_reset;
    logic [NUM_CH-1:0]     ch_start;
    logic [NUM_CH-1:0]     ch_stop;
    logic [NUM_CH-1:0]     ch_run;
    logic [NUM_CH-1:0]     ch_bank;
    logic [2*NUM_CH-1:0]   use_drifted;
    logic [SYNC_W-1:0]     sync_sel;
    logic [MODE_W-1:0]     mode;

    modport master (
        output ctrl_wr, ctrl_data, sync_tick,
        input  ctrl_ack, ch_reset, ch_start, ch_stop, ch_run, ch_bank,
               use_drifted, sync_sel, mode
    );

    modport slave (
        input  ctrl_wr, ctrl_data, sync_tick,
        output ctrl_ack, ch_reset, ch_start, ch_stop, ch_run, ch_bank,
               use_drifted, sync_sel, mode
    );
endinterface

// File: rtl/control_sequencer.sv
// Per-channel pattern sequencer: edge-detects command bits of a written control
// word against a shadow copy and runs one IDLE/ARMED/RUNNING FSM per channel.
module control_sequencer #(
    parameter int NUM_CH = 2,
    parameter int SYNC_W = 2,
    parameter int MODE_W = 3
) (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.slave  bus
);
    localparam int CTRL_W = 6 * NUM_CH + SYNC_W + MODE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUNNING
    } ch_state_t;

    ch_state_t            state [NUM_CH];
    logic [NUM_CH-1:0]    pending;

    // Shadow of the command bits; drift, sync_sel and mode live in their output registers.
    logic [NUM_CH-1:0]    sh_reset, sh_start, sh_stop, sh_switch;

    logic [NUM_CH-1:0]    wr_reset, wr_start, wr_stop, wr_switch;
    logic [2*NUM_CH-1:0]  wr_drift;
    logic [SYNC_W-1:0]    wr_sync_sel;
    logic [MODE_W-1:0]    wr_mode;
    logic [NUM_CH-1:0]    edge_reset, edge_start, edge_stop, edge_switch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_field
        assign wr_reset[g]         = bus.ctrl_data[6*g];
        assign wr_start[g]         = bus.ctrl_data[6*g+1];
        assign wr_stop[g]          = bus.ctrl_data[6*g+2];
        assign wr_switch[g]        = bus.ctrl_data[6*g+3];
        assign wr_drift[2*g +: 2]  = bus.ctrl_data[6*g+4 +: 2];
    end

    assign wr_sync_sel = bus.ctrl_data[6*NUM_CH +: SYNC_W];
    assign wr_mode     = bus.ctrl_data[CTRL_W-1 -: MODE_W];

    // Only 0->1 transitions against the previous word are commands.
    assign edge_reset  = {NUM_CH{bus.ctrl_wr}} & wr_reset  & ~sh_reset;
    assign edge_start  = {NUM_CH{bus.ctrl_wr}} & wr_start  & ~sh_start;
    assign edge_stop   = {NUM_CH{bus.ctrl_wr}} & wr_stop   & ~sh_stop;
    assign edge_switch = {NUM_CH{bus.ctrl_wr}} & wr_switch & ~sh_switch;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bus.ch_run = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_run[i] = (state[i] == ST_RUNNING);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= ST_IDLE;
            end
            pending         <= '0;
            sh_reset        <= '0;
            sh_start        <= '0;
            sh_stop         <= '0;
            sh_switch       <= '0;
            bus.ctrl_ack    <= 1'b0;
            bus.ch_reset    <= '0;
            bus.ch_start    <= '0;
            bus.ch_stop     <= '0;
            bus.ch_bank     <= '0;
            bus.use_drifted <= '0;
            bus.sync_sel    <= '0;
            bus.mode        <= '0;
        end else begin
            bus.ctrl_ack <= bus.ctrl_wr;
            bus.ch_reset <= '0;
            bus.ch_start <= '0;
            bus.ch_stop  <= '0;

            if (bus.ctrl_wr) begin
                sh_reset        <= wr_reset;
                sh_start        <= wr_start;
                sh_stop         <= wr_stop;
                sh_switch       <= wr_switch;
                bus.use_drifted <= wr_drift;
                bus.sync_sel    <= wr_sync_sel;
                bus.mode        <= wr_mode;
            end

            // Priority reset > stop > start; sync_tick is judged against the pre-write state.
            for (int i = 0; i < NUM_CH; i++) begin
                if (edge_reset[i]) begin
                    state[i]        <= ST_IDLE;
                    pending[i]      <= 1'b0;
                    bus.ch_bank[i]  <= 1'b0;
                    bus.ch_reset[i] <= 1'b1;
                end else if (edge_stop[i]) begin
                    if (state[i] != ST_IDLE) begin
                        state[i]       <= ST_IDLE;
                        pending[i]     <= 1'b0;
                        bus.ch_stop[i] <= 1'b1;
                    end
                end else begin
                    case (state[i])
                        ST_IDLE: begin
                            if (edge_start[i]) begin
                                if (wr_sync_sel == '0) begin
                                    state[i]        <= ST_RUNNING;
                                    bus.ch_start[i] <= 1'b1;
                                end else begin
                                    state[i] <= ST_ARMED;
                                end
                            end
                        end
                        ST_ARMED: begin
                            if (bus.sync_tick) begin
                                state[i]        <= ST_RUNNING;
                                bus.ch_start[i] <= 1'b1;
                            end
                        end
                        ST_RUNNING: begin
                            // A switch arriving while one is pending is absorbed, never double-toggles.
                            if (pending[i] && bus.sync_tick) begin
                                bus.ch_bank[i] <= ~bus.ch_bank[i];
                                pending[i]     <= 1'b0;
                            end else if (edge_switch[i]) begin
                                pending[i] <= 1'b1;
                            end
                        end
                        default: state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: stimulus pushes expected output
// snapshots, a negedge monitor pops one whenever the outputs change or pulse.
module tb_control_sequencer;
    localparam int NUM_CH = 2;
    localparam int SYNC_W = 2;
    localparam int MODE_W = 3;

    localparam logic [5:0] C_RST = 6'b000001;
    localparam logic [5:0] C_STA = 6'b000010;
    localparam logic [5:0] C_STO = 6'b000100;
    localparam logic [5:0] C_SW  = 6'b001000;
    localparam logic [5:0] C_DR1 = 6'b100000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    control_sequencer_if #(.NUM_CH(NUM_CH), .SYNC_W(SYNC_W), .MODE_W(MODE_W)) bus ();

    control_sequencer #(.NUM_CH(NUM_CH), .SYNC_W(SYNC_W), .MODE_W(MODE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ack;
        logic [1:0] rst;
        logic [1:0] sta;
        logic [1:0] sto;
        logic [1:0] run;
        logic [1:0] bank;
        logic [3:0] drift;
        logic [1:0] ss;
        logic [2:0] md;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ev_idx   = 0;

    logic [1:0] exp_run   = '0;
    logic [1:0] exp_bank  = '0;
    logic [3:0] exp_drift = '0;
    logic [1:0] exp_ss    = '0;
    logic [2:0] exp_md    = '0;
    logic       mon_en    = 1'b0;
    snap_t      prev_s;
    snap_t      mon_s;

    function automatic snap_t cur_snap();
        snap_t s;
        s.ack   = bus.ctrl_ack;
        s.rst   = bus.ch_reset;
        s.sta   = bus.ch_start;
        s.sto   = bus.ch_stop;
        s.run   = bus.ch_run;
        s.bank  = bus.ch_bank;
        s.drift = bus.use_drifted;
        s.ss    = bus.sync_sel;
        s.md    = bus.mode;
        return s;
    endfunction

    function automatic snap_t exp_snap(input logic ack, input logic [1:0] r, st, sp);
        snap_t s;
        s.ack   = ack;
        s.rst   = r;
        s.sta   = st;
        s.sto   = sp;
        s.run   = exp_run;
        s.bank  = exp_bank;
        s.drift = exp_drift;
        s.ss    = exp_ss;
        s.md    = exp_md;
        return s;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Pulse snapshot followed by its all-pulses-low follow-up cycle.
    task automatic push_ev(input logic ack, input logic [1:0] r, st, sp);
        exp_q.push_back(exp_snap(ack, r, st, sp));
        if (ack || (r != 0) || (st != 0) || (sp != 0))
            exp_q.push_back(exp_snap(1'b0, 2'b00, 2'b00, 2'b00));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_s = cur_snap();
            if ((mon_s !== prev_s) || mon_s.ack || (mon_s.rst != 0) ||
                (mon_s.sta != 0) || (mon_s.sto != 0)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected none", mon_s);
                end else begin
                    check($sformatf("event_%0d", ev_idx), mon_s, exp_q.pop_front());
                end
                ev_idx++;
            end
            prev_s = mon_s;
        end
    end

    task automatic wr(input logic [5:0] c0, c1, input logic [1:0] ss, input logic [2:0] md,
                      input logic tk, input logic [1:0] r, st, sp, run, bank);
        @(posedge clk); #1;
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_data = {md, ss, c1, c0};
        bus.sync_tick = tk;
        exp_run   = run;
        exp_bank  = bank;
        exp_drift = {c1[5:4], c0[5:4]};
        exp_ss    = ss;
        exp_md    = md;
        push_ev(1'b1, r, st, sp);
        @(posedge clk); #1;
        bus.ctrl_wr   = 1'b0;
        bus.sync_tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic tick(input logic [1:0] st, run, bank);
        logic changed;
        @(posedge clk); #1;
        bus.sync_tick = 1'b1;
        changed  = (run != exp_run) || (bank != exp_bank);
        exp_run  = run;
        exp_bank = bank;
        if (st != 0)
            push_ev(1'b0, 2'b00, st, 2'b00);
        else if (changed)
            exp_q.push_back(exp_snap(1'b0, 2'b00, 2'b00, 2'b00));
        @(posedge clk); #1;
        bus.sync_tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Reset while busy, with a write and a tick offered that must both be ignored.
    task automatic mid_reset();
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_data = {3'b111, 2'b00, C_STA, C_STA};
        bus.sync_tick = 1'b1;
        exp_run   = '0;
        exp_bank  = '0;
        exp_drift = '0;
        exp_ss    = '0;
        exp_md    = '0;
        exp_q.push_back(exp_snap(1'b0, 2'b00, 2'b00, 2'b00));
        @(posedge clk); #1;
        bus.ctrl_wr   = 1'b0;
        bus.sync_tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_data = {3'b101, 2'b00, C_STA, C_STA};
        bus.sync_tick = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", cur_snap(), '0);
        bus.ctrl_wr   = 1'b0;
        bus.sync_tick = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b0;
        prev_s = '0;
        mon_en = 1'b1;
        idle(2);

        // Immediate start, drift select on ch1, then an identical rewrite
        wr(C_STA, C_DR1, 2'd0, 3'b101, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        wr(C_STA, C_DR1, 2'd0, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);

        // Synced start on ch1: armed until the tick
        wr(C_STA, C_STA, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        idle(4);
        tick(2'b10, 2'b11, 2'b00);

        // Switch on ch0, toggles once on the first tick only
        wr(C_STA | C_SW, C_STA, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        idle(2);
        tick(2'b00, 2'b11, 2'b01);
        idle(2);
        tick(2'b00, 2'b11, 2'b01);

        // Reset+stop+start together: reset wins, bank cleared
        wr(6'b0, C_STA, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01);
        wr(C_RST | C_STO | C_STA, C_STA, 2'd1, 3'b101, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);

        // Start with a coincident tick arms without consuming it
        wr(6'b0, C_STA, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        wr(C_STA, C_STA, 2'd1, 3'b101, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        idle(2);
        tick(2'b01, 2'b11, 2'b00);

        // Stop while running pulses; stop while idle does not
        wr(C_STA, C_STA | C_STO, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00);
        wr(C_STA, 6'b0, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        wr(C_STA, C_STO, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);

        // ch0 armed, ch1 running with switch pending, then reset
        wr(6'b0, 6'b0, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        wr(C_STO, C_STA, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tick(2'b10, 2'b10, 2'b00);
        wr(C_STA, C_STA | C_SW, 2'd1, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        mid_reset();
        idle(3);
        tick(2'b00, 2'b00, 2'b00);
        idle(3);

        // Shadow is clear after reset, so start is a fresh edge
        wr(C_STA, 6'b0, 2'd0, 3'b000, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d events outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of pattern channels (1..8).
REQ-002 The block SHALL have parameter SYNC_W, default 2, width of the sync-select field.
REQ-003 The block SHALL have parameter MODE_W, default 3, width of the global mode field (use_dac, use_clp, use_cal at default).
REQ-004 The block SHALL use localparam CTRL_W = 6*NUM_CH + SYNC_W + MODE_W; layout from LSB: per channel i, bits [6i+5:6i] = {drift[1:0], switch, stop, start, reset}, then sync_sel, then mode.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, ports: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-006 ctrl_wr  in  1  control-word write strobe.
REQ-007 ctrl_data  in  CTRL_W  control word, sampled when ctrl_wr=1.
REQ-008 sync_tick  in  1  one-cycle external sync event.
REQ-009 ctrl_ack  out  1  one-cycle acknowledge of a write.
REQ-010 ch_reset, ch_start, ch_stop  out  NUM_CH each  one-cycle per-channel event pulses.
REQ-011 ch_run  out  NUM_CH  per-channel running level.
REQ-012 ch_bank  out  NUM_CH  per-channel active pattern bank (toggled by switch).
REQ-013 use_drifted  out  2*NUM_CH  per-channel drift select level; sync_sel  out  SYNC_W; mode  out  MODE_W.

Function
REQ-014 The block SHALL hold a shadow register of the last written word; command bits (reset/start/stop/switch) SHALL act only on 0->1 transitions relative to the shadow, so rewriting an unchanged word issues no command.
REQ-015 On a ctrl_wr in cycle T, shadow, use_drifted, sync_sel, mode SHALL update and ctrl_ack SHALL be 1 in cycle T+1; channel commands from that write SHALL take effect in cycle T+1.
REQ-016 Each channel SHALL run an FSM with states IDLE, ARMED, RUNNING.
REQ-017 Start edge in IDLE: if sync_sel==0 go RUNNING with ch_start=1 at T+1; else go ARMED.
REQ-018 ARMED SHALL go RUNNING on a cycle with sync_tick=1, with ch_start=1 in the following cycle; start edges in ARMED or RUNNING SHALL be ignored.
REQ-019 Stop edge in ARMED or RUNNING SHALL go IDLE with ch_stop=1 at T+1; stop in IDLE SHALL be ignored (no pulse).
REQ-020 Reset edge SHALL force IDLE from any state, clear the channel's pending switch and ch_bank, and pulse ch_reset=1 at T+1.
REQ-021 Priority for simultaneous edges on one channel: reset > stop > start; switch SHALL be dropped when reset or stop is also present.
REQ-022 Switch edge while RUNNING SHALL set a pending flag; ch_bank SHALL toggle in the cycle after the next sync_tick, then pending clears; switch in IDLE/ARMED SHALL be ignored; a second switch while pending SHALL not double-toggle.
REQ-023 A sync_tick coinciding with a write SHALL be evaluated against the pre-write state (a start in the same cycle does not consume that tick).
REQ-024 ch_run SHALL equal (state==RUNNING); all pulses SHALL be exactly one cycle wide and registered.
REQ-025 Channels SHALL operate independently; one write MAY command several channels.

Reset
REQ-026 While reset=1: all FSMs IDLE, shadow=0, all outputs 0, pending flags cleared; any ctrl_wr or sync_tick SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL take effect on the next clk edge regardless of FSM state, with no event pulses emitted.
REQ-028 After reset deassertion, a write with start=1 SHALL be seen as a rising edge (shadow is 0).

Verification (NUM_CH=2, SYNC_W=2, MODE_W=3)
REQ-029 Write ch0 start, sync_sel=0 -> ch_start[0]=1 for one cycle at T+1, ch_run[0]=1, ctrl_ack=1 at T+1.
REQ-030 Write ch1 start, sync_sel=1, sync_tick 5 cycles later -> ch_run[1]=0 until tick, ch_start[1] pulse the cycle after tick, then ch_run[1]=1.
REQ-031 Rewrite identical word with start=1 while RUNNING -> no ch_start pulse, state unchanged, ctrl_ack still pulses.
REQ-032 ch0 RUNNING, write reset|stop|start bits together -> ch_reset[0]=1 only, ch_stop[0]=0, ch_run[0]=0, ch_bank[0]=0.
REQ-033 ch0 RUNNING, write switch then two sync_ticks -> ch_bank[0] toggles 0->1 once, after first tick only.
REQ-034 Assert reset while ch0 ARMED and ch1 RUNNING with pending switch -> next cycle all outputs 0; later sync_tick produces no ch_start or bank change.
